// File: rtl/aes_result_capture_if.sv
// ----------------------------------------------------------------------------
// aes_result_capture_if
//
// Purpose: read-side handshake bundle of the AES result capture FIFO.
//
// Signals:
//   res_valid  1    FIFO holds at least one result (driven by the capture stage)
//   res_ready  1    consumer accepts the head entry this cycle
//   res_data   128  head entry ciphertext
//   res_tag    8    head entry sequence number
//
// Modports:
//   master  the capture stage (produces results)
//   slave   the consumer (accepts results)
// ----------------------------------------------------------------------------
interface aes_result_capture_if;
    logic         res_valid;
    logic         res_ready;
    logic [127:0] res_data;
    logic [7:0]   res_tag;

    modport master (
        output res_valid,
        output res_data,
        output res_tag,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_tag,
        output res_ready
    );
endinterface : aes_result_capture_if

// File: rtl/aes_result_capture.sv
// ----------------------------------------------------------------------------
// aes_result_capture
//
// Purpose: capture stage behind the pipelined AES top. Each cycle that carries
// a real (key, state) pair is tagged with an 8-bit sequence number. A valid/tag
// delay line of LATENCY stages follows it through the AES pipeline, so the
// matching ciphertext can be captured into a small show-ahead FIFO that is
// read over a ready/valid handshake. A side monitor counts the cycles on which
// the 64-bit Capacitance bus changes value.
//
// Parameters:
//   LATENCY  cycles from state/key presentation to matching out (1..64)
//   DEPTH    result FIFO entries, power of two (2..16)
//
// Ports:
//   clk             clock, all logic on the rising edge
//   rst             synchronous active-high reset
//   in_valid        AES top is given a real vector this cycle
//   aes_out         AES top ciphertext output (128 bit)
//   cap             AES top Capacitance output (64 bit)
//   res             read side: res_valid/res_ready/res_data/res_tag
//   level           FIFO occupancy, 0..DEPTH
//   overflow        sticky, a result was dropped because the FIFO was full
//   cap_toggle_cnt  saturating count of cycles on which cap changed
// ----------------------------------------------------------------------------
module aes_result_capture #(
    parameter int LATENCY = 21,
    parameter int DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [127:0]                aes_out,
    input  logic [63:0]                 cap,
    aes_result_capture_if.master        res,
    output logic [4:0]                  level,
    output logic                        overflow,
    output logic [15:0]                 cap_toggle_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [AW-1:0] ptr_t;

    typedef struct packed {
        logic [7:0]   tag;
        logic [127:0] data;
    } entry_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [7:0]  seq_q, seq_d;

    logic        dl_v_q   [LATENCY];
    logic [7:0]  dl_tag_q [LATENCY];

    entry_t      mem_q [DEPTH];
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    logic [4:0]  count_q, count_d;
    logic        overflow_q, overflow_d;

    logic [63:0] cap_prev_q;
    logic        prev_ok_q;
    logic [15:0] cnt_q, cnt_d;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic        cap_v;
    logic [7:0]  cap_tag;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push;
    logic        drop;
    logic        cap_changed;

    // Output of the last delay-line stage lines up with aes_out of the same vector.
    assign cap_v   = dl_v_q[LATENCY-1];
    assign cap_tag = dl_tag_q[LATENCY-1];

    always_comb begin
        // NOTE: every signal driven here gets a value before any condition, so
        // no path leaves it unassigned and no latch is inferred.
        empty       = (count_q == 5'd0);
        full        = (count_q == 5'(DEPTH));
        pop         = !empty && res.res_ready;
        // A full FIFO still accepts a push when the head leaves in the same
        // cycle; an empty FIFO never forwards the incoming entry straight out.
        push        = cap_v && (!full || pop);
        drop        = cap_v && full && !pop;
        cap_changed = prev_ok_q && (cap != cap_prev_q);

        seq_d       = in_valid ? seq_q + 8'd1 : seq_q;
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d     = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase

        overflow_d  = overflow_q | drop;

        cnt_d       = cnt_q;
        if (cap_changed && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Sequence counter and valid/tag delay line
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the values present before the edge, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q <= 8'd0;
            for (int i = 0; i < LATENCY; i++) begin
                dl_v_q[i]   <= 1'b0;
                dl_tag_q[i] <= 8'd0;
            end
        end else begin
            seq_q       <= seq_d;
            dl_v_q[0]   <= in_valid;
            dl_tag_q[0] <= seq_q;
            for (int i = 1; i < LATENCY; i++) begin
                dl_v_q[i]   <= dl_v_q[i-1];
                dl_tag_q[i] <= dl_tag_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------------
    // NOTE: the storage array is reset as well, so the show-ahead head reads
    // as zero rather than X while the FIFO is empty after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 5'd0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{tag: cap_tag, data: aes_out};
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------------
    // Capacitance toggle monitor
    // ------------------------------------------------------------------------
    // prev_ok_q holds off counting until cap_prev_q has captured a real sample,
    // so the first sample after reset never counts as a change.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_prev_q <= 64'd0;
            prev_ok_q  <= 1'b0;
            cnt_q      <= 16'd0;
        end else begin
            cap_prev_q <= cap;
            prev_ok_q  <= 1'b1;
            cnt_q      <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign res.res_valid  = !empty;
    assign res.res_data   = mem_q[rd_ptr_q].data;
    assign res.res_tag    = mem_q[rd_ptr_q].tag;
    assign level          = count_q;
    assign overflow       = overflow_q;
    assign cap_toggle_cnt = cnt_q;

endmodule : aes_result_capture

// File: tb/tb_aes_result_capture.sv
// ----------------------------------------------------------------------------
// tb_aes_result_capture
//
// Directed bench for aes_result_capture (LATENCY=21, DEPTH=4). Inputs change
// 1 ns after a rising edge and outputs are sampled there as well, away from
// the active edge. Expected data for multi-vector tests comes from pat(): the
// bench drives aes_out = pat(c) after edge c, so the ciphertext captured for a
// vector whose in_valid was set after edge c is pat(c + 21).
// ----------------------------------------------------------------------------
module tb_aes_result_capture;

    localparam int LAT = 21;
    localparam int DEP = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] aes_out;
    logic [63:0]  cap;
    logic [4:0]   level;
    logic         overflow;
    logic [15:0]  cap_toggle_cnt;

    aes_result_capture_if res_if ();

    aes_result_capture #(.LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .aes_out        (aes_out),
        .cap            (cap),
        .res            (res_if),
        .level          (level),
        .overflow       (overflow),
        .cap_toggle_cnt (cap_toggle_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit auto_data = 1'b0;
    int iss [8];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int c);
        logic [31:0] cv;
        cv = 32'(c);
        return {32'hC0DE0000 ^ cv, 32'h12345678, ~cv, cv * 32'd3};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (auto_data) aes_out = pat(cyc);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        res_if.res_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic issue(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            iss[i]   = cyc;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        int c0;
        int saw;
        rst = 1'b1;
        in_valid = 1'b0;
        aes_out = '0;
        cap = 64'h0123_4567_89AB_CDEF;
        res_if.res_ready = 1'b0;

        // ---------------- reset state ----------------
        do_reset();
        check("rst_valid",    res_if.res_valid, 1'b0);
        check("rst_level",    level,            5'd0);
        check("rst_overflow", overflow,         1'b0);
        check("rst_capcnt",   cap_toggle_cnt,   16'd0);
        check("rst_data",     res_if.res_data,  128'd0);
        check("rst_tag",      res_if.res_tag,   8'd0);

        // ---------------- single vector, ready held high ----------------
        res_if.res_ready = 1'b1;
        c0 = cyc;
        issue(1);
        wait_until(c0 + LAT);
        check("single_not_early", res_if.res_valid, 1'b0);
        aes_out = 128'h3925841d02dc09fbdc118597196a0b32;
        step();
        aes_out = '0;
        check("single_valid", res_if.res_valid, 1'b1);
        check("single_tag",   res_if.res_tag,   8'd0);
        check("single_data",  res_if.res_data,  128'h3925841d02dc09fbdc118597196a0b32);
        check("single_level", level,            5'd1);
        step();
        check("single_popped_valid", res_if.res_valid, 1'b0);
        check("single_popped_level", level,            5'd0);

        // ---------------- back-to-back 4, ready low ----------------
        auto_data = 1'b1;
        do_reset();
        issue(4);
        wait_until(iss[3] + LAT + 1);
        check("b2b_level",    level,    5'd4);
        check("b2b_overflow", overflow, 1'b0);
        res_if.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b_tag%0d", i),  res_if.res_tag,  8'(i));
            check($sformatf("b2b_data%0d", i), res_if.res_data, pat(iss[i] + LAT));
            step();
        end
        res_if.res_ready = 1'b0;
        check("b2b_empty", res_if.res_valid, 1'b0);

        // ---------------- overflow: 6 into depth 4 ----------------
        do_reset();
        issue(6);
        wait_until(iss[5] + LAT + 1);
        check("ovf_level", level,    5'd4);
        check("ovf_flag",  overflow, 1'b1);
        res_if.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_tag%0d", i),  res_if.res_tag,  8'(i));
            check($sformatf("ovf_data%0d", i), res_if.res_data, pat(iss[i] + LAT));
            step();
        end
        res_if.res_ready = 1'b0;
        check("ovf_empty",  res_if.res_valid, 1'b0);
        check("ovf_sticky", overflow,         1'b1);

        // ---------------- full with simultaneous push/pop ----------------
        do_reset();
        issue(5);
        wait_until(iss[3] + LAT + 1);
        check("fpp_full_level", level, 5'd4);
        res_if.res_ready = 1'b1;
        step();
        check("fpp_level",    level,    5'd4);
        check("fpp_overflow", overflow, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("fpp_tag%0d", k), res_if.res_tag, 8'(k));
            if (k == 4) check("fpp_data4", res_if.res_data, pat(iss[4] + LAT));
            step();
        end
        res_if.res_ready = 1'b0;
        check("fpp_empty", res_if.res_valid, 1'b0);

        // ---------------- reset mid-flight ----------------
        do_reset();
        issue(3);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        saw = 0;
        repeat (30) begin
            step();
            if (res_if.res_valid) saw++;
        end
        check("rmf_no_results", 32'(saw), 32'd0);
        check("rmf_level",      level,    5'd0);
        issue(1);
        wait_until(iss[0] + LAT + 1);
        check("rmf_new_valid", res_if.res_valid, 1'b1);
        check("rmf_new_tag",   res_if.res_tag,   8'd0);
        check("rmf_new_data",  res_if.res_data,  pat(iss[0] + LAT));

        // ---------------- capacitance monitor ----------------
        auto_data = 1'b0;
        cap = 64'hAAAA_0000_5555_FFFF;
        do_reset();
        // First sample after reset differs from the value held during reset
        // and must not count.
        cap = 64'h1111_2222_3333_4444;
        repeat (10) step();
        check("cap_const", cap_toggle_cnt, 16'd0);
        for (int n = 1; n <= 70000; n++) begin
            cap = ~cap;
            step();
            if (n == 5)     check("cap_5",     cap_toggle_cnt, 16'd5);
            if (n == 65534) check("cap_65534", cap_toggle_cnt, 16'hFFFE);
            if (n == 65535) check("cap_65535", cap_toggle_cnt, 16'hFFFF);
        end
        check("cap_saturated", cap_toggle_cnt, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_aes_result_capture
